mem_access_unit: RTL and testbench

//  Initiator side of the 20-bit x 32-word main-memory data port (mem_addr, data, wr_en, q_mem).

---
 rtl/mem_access_unit_if.sv | 32 +++
 rtl/mem_access_unit.sv | 109 ++++++++++
 tb/tb_mem_access_unit.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_if.sv
// Bundles the MEM-stage request/response handshake and the main-memory data port.
// master = pipeline/memory side, slave = mem_access_unit.
interface mem_access_unit_if #(
  parameter int unsigned AW = 5,
  parameter int unsigned DW = 20
);
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;

  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;

  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic          mem_wr_en;
  logic [DW-1:0] mem_q;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready, mem_q,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_addr, mem_data, mem_wr_en
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready, mem_q,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_addr, mem_data, mem_wr_en
  );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage initiator for the 20-bit x 32-word data memory: one load/store at a time,
// IDLE -> ACCESS -> RESP, with the top addresses read-only.
module mem_access_unit #(
  parameter int unsigned     AW        = 5,
  parameter int unsigned     DW        = 20,
  parameter logic [AW-1:0]   PROT_BASE = AW'(28)
) (
  input logic              i_clk,
  input logic              i_rst,
  mem_access_unit_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_e;

  state_e        r_state;
  state_e        w_next_state;
  logic          w_accept;
  logic          w_rsp_take;
  logic          w_prot;

  logic [AW-1:0] r_mem_addr;
  logic [DW-1:0] r_mem_data;
  logic          r_mem_wr_en;
  logic          r_err_q;
  logic [DW-1:0] r_rsp_rdata;
  logic          r_rsp_err;
  logic          r_rsp_valid;

  assign w_prot = (bus.req_addr >= PROT_BASE);

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    // NOTE: every variable gets a default before the case so no path infers a latch.
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_rsp_take   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (bus.req_valid) begin
          w_accept     = 1'b1;
          w_next_state = S_ACCESS;
        end
      end
      S_ACCESS: w_next_state = S_RESP;
      S_RESP: begin
        if (bus.rsp_ready) begin
          w_rsp_take   = 1'b1;
          w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // The write lands at the ACCESS negedge, so sampling mem_q at the closing posedge
  // returns the freshly stored word for stores and the old word for dropped ones.
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (i_rst) begin
      r_mem_addr  <= '0;
      r_mem_data  <= '0;
      r_mem_wr_en <= 1'b0;
      r_err_q     <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
      r_rsp_valid <= 1'b0;
    end else begin
      if (w_accept) begin
        r_mem_addr  <= bus.req_addr;
        r_mem_data  <= bus.req_wdata;
        r_mem_wr_en <= bus.req_we & ~w_prot;
        r_err_q     <= bus.req_we & w_prot;
      end
      if (r_state == S_ACCESS) begin
        r_rsp_rdata <= bus.mem_q;
        r_rsp_err   <= r_err_q;
        r_rsp_valid <= 1'b1;
        r_mem_wr_en <= 1'b0;
      end
      if (w_rsp_take) r_rsp_valid <= 1'b0;
    end
  end

  assign bus.req_ready = (r_state == S_IDLE);
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.rsp_err   = r_rsp_err;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_data  = r_mem_data;
  assign bus.mem_wr_en = r_mem_wr_en;

  a_wr_only_in_access: assert property (@(posedge i_clk) disable iff (i_rst)
    r_mem_wr_en |-> (r_state == S_ACCESS));

  a_valid_tracks_resp: assert property (@(posedge i_clk) disable iff (i_rst)
    r_rsp_valid == (r_state == S_RESP));

  a_rsp_held: assert property (@(posedge i_clk) disable iff (i_rst)
    (r_state == S_RESP && !bus.rsp_ready) |=> ($stable(r_rsp_rdata) && $stable(r_rsp_err)));

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: vector table plus scoreboard queue,
// with hand-written stall and mid-access reset sequences against a negedge-write memory.
module tb_mem_access_unit;

  localparam int AW = 5;
  localparam int DW = 20;
  localparam logic [AW-1:0] PROT = 5'd28;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_access_unit_if #(.AW(AW), .DW(DW)) bus ();

  mem_access_unit #(.AW(AW), .DW(DW), .PROT_BASE(PROT)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  function automatic logic [DW-1:0] preload(input int i);
    if (i == 31)      return 20'h00005;
    else if (i == 29) return 20'h0001B;
    else              return 20'h10000 | 20'(i);
  endfunction

  logic [DW-1:0] mem [32];
  logic          mem_init = 1'b1;
  always @(negedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 32; i++) mem[i] <= preload(i);
      mem_init <= 1'b0;
    end else if (bus.mem_wr_en) begin
      mem[bus.mem_addr] <= bus.mem_data;
    end
  end
  assign bus.mem_q = mem[bus.mem_addr];

  logic [DW-1:0] ref_mem [32];

  typedef struct {
    logic [DW-1:0] rdata;
    logic          err;
    logic          wr;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp_rdata;
    logic          exp_err;
    logic          exp_wr;
  } vec_t;
  vec_t vecs[11];

  int n_vec  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Entered and left at posedge+1 with the unit idle.
  task automatic run_req(input string tag, input logic we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata, input logic [DW-1:0] exp_rdata,
                         input logic exp_err, input logic exp_wr);
    exp_t e;
    int   edges, lat, wr;
    logic acc, got;
    e.rdata = exp_rdata; e.err = exp_err; e.wr = exp_wr;
    sb.push_back(e);
    if (we && addr < PROT) ref_mem[addr] = wdata;
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_addr = addr; bus.req_wdata = wdata;
    bus.rsp_ready = 1'b1;
    edges = 0; wr = 0; acc = 1'b0;
    while (!acc && edges < 20) begin
      @(negedge clk);
      acc = bus.req_ready;
      if (bus.mem_wr_en) wr++;
      @(posedge clk); #1;
      edges++;
    end
    bus.req_valid = 1'b0;
    if (!acc) begin
      check({tag, "_accept_timeout"}, 0, 1);
      void'(sb.pop_front());
      return;
    end
    lat = 0; got = 1'b0;
    while (!got && lat < 20) begin
      @(negedge clk);
      if (bus.mem_wr_en) wr++;
      if (bus.rsp_valid) got = 1'b1;
      else begin
        @(posedge clk); #1;
        lat++;
      end
    end
    e = sb.pop_front();
    check({tag, "_latency"}, edges + lat, got ? 2 : 99);
    check({tag, "_rdata"}, bus.rsp_rdata, e.rdata);
    check({tag, "_err"}, bus.rsp_err, e.err);
    check({tag, "_wr_cycles"}, wr, e.wr ? 1 : 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{1'b0, 5'd31, 20'h00000, 20'h00005, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 5'd3,  20'hABCDE, 20'hABCDE, 1'b0, 1'b1};
    vecs[2]  = '{1'b0, 5'd3,  20'h00000, 20'hABCDE, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 5'd29, 20'hFFFFF, 20'h0001B, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 5'd29, 20'h00000, 20'h0001B, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 5'd27, 20'h13579, 20'h13579, 1'b0, 1'b1};
    vecs[6]  = '{1'b1, 5'd28, 20'h22222, 20'h1001C, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 5'd27, 20'h00000, 20'h13579, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 5'd28, 20'h00000, 20'h1001C, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 5'd0,  20'h00001, 20'h00001, 1'b0, 1'b1};
    vecs[10] = '{1'b1, 5'd31, 20'hAAAAA, 20'h00005, 1'b1, 1'b0};

    for (int i = 0; i < 32; i++) ref_mem[i] = preload(i);
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    bus.rsp_ready = 1'b0;

    // Reset for two cycles, then inspect reset values.
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_req_ready", bus.req_ready, 1);
    check("reset_rsp_valid", bus.rsp_valid, 0);
    check("reset_mem_wr_en", bus.mem_wr_en, 0);
    check("reset_rsp_rdata", bus.rsp_rdata, 0);
    check("reset_rsp_err",   bus.rsp_err, 0);
    check("reset_mem_addr",  bus.mem_addr, 0);
    @(posedge clk); #1;

    for (int i = 0; i < 11; i++)
      run_req($sformatf("vec%0d", i), vecs[i].we, vecs[i].addr, vecs[i].wdata,
              vecs[i].exp_rdata, vecs[i].exp_err, vecs[i].exp_wr);

    // Response stall with a held request: nothing may be re-accepted.
    begin
      exp_t e;
      e.rdata = 20'h55555; e.err = 1'b0; e.wr = 1'b1;
      sb.push_back(e);
      ref_mem[6] = 20'h55555;
      bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 5'd6; bus.req_wdata = 20'h55555;
      bus.rsp_ready = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      e = sb.pop_front();
      check("stall_rsp_valid", bus.rsp_valid, 1);
      check("stall_rdata", bus.rsp_rdata, e.rdata);
      check("stall_err", bus.rsp_err, e.err);
      bus.req_wdata = 20'h77777;
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        check($sformatf("stall%0d_rsp_valid", c), bus.rsp_valid, 1);
        check($sformatf("stall%0d_rdata", c), bus.rsp_rdata, 20'h55555);
        check($sformatf("stall%0d_req_ready", c), bus.req_ready, 0);
        check($sformatf("stall%0d_mem_wr_en", c), bus.mem_wr_en, 0);
        @(posedge clk); #1;
      end
      bus.req_valid = 1'b0;
      bus.rsp_ready = 1'b1;
      @(posedge clk); #1;
      check("stall_release_req_ready", bus.req_ready, 1);
      check("stall_release_rsp_valid", bus.rsp_valid, 0);
      run_req("stall_readback", 1'b0, 5'd6, 20'h0, 20'h55555, 1'b0, 1'b0);
    end

    // Reset during ACCESS of a store: write completes, response vanishes.
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 5'd4; bus.req_wdata = 20'h12345;
    @(posedge clk); #1;
    rst = 1'b1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    check("rst_access_wr_en", bus.mem_wr_en, 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    ref_mem[4] = 20'h12345;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("rst%0d_rsp_valid", c), bus.rsp_valid, 0);
      check($sformatf("rst%0d_req_ready", c), bus.req_ready, 1);
      @(posedge clk); #1;
    end
    check("rst_rsp_rdata", bus.rsp_rdata, 0);
    check("rst_mem_wr_en", bus.mem_wr_en, 0);
    run_req("rst_readback", 1'b0, 5'd4, 20'h0, 20'h12345, 1'b0, 1'b0);

    // Random traffic checked against a reference memory.
    for (int i = 0; i < 16; i++) begin
      logic          we;
      logic [AW-1:0] a;
      logic [DW-1:0] d, exp_d;
      logic          prot;
      we   = 1'($urandom_range(0, 1));
      a    = AW'($urandom_range(0, 31));
      d    = DW'($urandom);
      prot = (a >= PROT);
      exp_d = (we && !prot) ? d : ref_mem[a];
      run_req($sformatf("rnd%0d", i), we, a, d, exp_d, we & prot, we & ~prot);
    end

    check("scoreboard_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
